idli_vop_seq_m: RTL and testbench



---
 rtl/idli_pkg.sv | 76 +++++++
 rtl/idli_vop_pick_m.sv | 39 +++
 rtl/idli_vop_seq_m.sv | 212 +++++++++++++++++++++
 tb/tb_idli_vop_seq_m.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// Shared types for the idli virtual-op sequencer: op encoding, sequencer
// states, op templates and the popcount helper used for stack adjustment.
package idli_pkg;

    // Width of a register index inside an op (covers up to 9 stack registers).
    localparam int REG_W = 4;

    typedef enum logic {
        VOP_LD = 1'b0,
        VOP_ST = 1'b1
    } vop_type_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD     = 3'd1,
        ST     = 3'd2,
        ADDR   = 3'd3,
        STK_LD = 3'd4,
        STK_ST = 3'd5
    } vop_state_t;

    // LHS operand source: register selected by b, or the SQI memory stream.
    typedef enum logic {
        LHS_REG = 1'b0,
        LHS_SQI = 1'b1
    } lhs_t;

    typedef enum logic [1:0] {
        RHS_REG  = 2'd0,
        RHS_IMM  = 2'd1,
        RHS_ZERO = 2'd2
    } rhs_t;

    typedef struct packed {
        logic [1:0]       p;            // predicate register
        logic             p_inv;        // invert predicate
        logic [REG_W-1:0] a;            // destination register
        logic             a_vld;        // destination written
        logic [REG_W-1:0] b;            // LHS register when alu_lhs == LHS_REG
        lhs_t             alu_lhs;
        rhs_t             alu_rhs;
        logic             alu_rhs_inv;  // with alu_cin turns ADD into SUB
        logic             alu_cin;
        logic             wr_sqi;       // result streamed out over SQI
        logic             wr_addr;      // result written to the address register
        logic             addr_lhs;     // address register loaded with the LHS value
    } op_t;

    // ADD.P A, SQI, 0 : load from memory stream into A.
    localparam op_t OP_LD = '{p: 2'b00, p_inv: 1'b0, a: '0, a_vld: 1'b1, b: '0,
                              alu_lhs: LHS_SQI, alu_rhs: RHS_ZERO,
                              alu_rhs_inv: 1'b0, alu_cin: 1'b0,
                              wr_sqi: 1'b0, wr_addr: 1'b0, addr_lhs: 1'b0};

    // ADD.P SQI, B, 0 : stream B out to memory.
    localparam op_t OP_ST = '{p: 2'b00, p_inv: 1'b0, a: '0, a_vld: 1'b0, b: '0,
                              alu_lhs: LHS_REG, alu_rhs: RHS_ZERO,
                              alu_rhs_inv: 1'b0, alu_cin: 1'b0,
                              wr_sqi: 1'b1, wr_addr: 1'b0, addr_lhs: 1'b0};

    // Stack address setup: register LHS plus immediate; push/pop fill in the rest.
    localparam op_t OP_ADDR = '{p: 2'b00, p_inv: 1'b0, a: '0, a_vld: 1'b0, b: '0,
                                alu_lhs: LHS_REG, alu_rhs: RHS_IMM,
                                alu_rhs_inv: 1'b0, alu_cin: 1'b0,
                                wr_sqi: 1'b0, wr_addr: 1'b0, addr_lhs: 1'b0};

    function automatic logic [3:0] popcnt4(input logic [8:0] m);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 9; i++) begin
            c = c + {3'b000, m[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/idli_vop_pick_m.sv
// Priority picker over a register mask: returns the index and one-hot of the
// selected set bit, plus a flag when it is the only bit left. msb_first
// selects highest-first instead of lowest-first order.
module idli_vop_pick_m #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     mask,
    input  logic             msb_first,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot,
    output logic             last
);

    // Scan in the direction opposite to priority so the winner is written last.
    always_comb begin
        idx    = '0;
        onehot = '0;
        if (msb_first) begin
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    idx       = IDX_W'(i);
                    onehot    = '0;
                    onehot[i] = 1'b1;
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (mask[i]) begin
                    idx       = IDX_W'(i);
                    onehot    = '0;
                    onehot[i] = 1'b1;
                end
            end
        end
        last = ((mask & ~onehot) == '0);
    end

endmodule

// File: rtl/idli_vop_seq_m.sv
// Virtual-op sequencer between decode and execute. Expands LD/ST and stack
// PUSH/POP into standard ops, one per 4-cycle slot, honouring execute hold.
// Optional build macro IDLI_VOP_POP_REVERSE_EN: POP walks the register mask
// highest bit first so PUSH and POP memory orders mirror each other.
module idli_vop_seq_m
    import idli_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int SP_REG   = 7
) (
    input  logic       i_vop_gck,
    input  logic       i_vop_rst_n,
    input  logic [3:0] i_vop_enc,
    input  logic       i_vop_enc_vld,
    input  vop_type_t  i_vop_type,
    input  logic       i_vop_type_vld,
    input  logic       i_vop_stack,
    input  logic [1:0] i_vop_ctr,
    input  logic       i_vop_hold,
    output op_t        o_vop_op,
    output logic       o_vop_op_vld,
    output logic [3:0] o_vop_imm,
    output logic       o_vop_busy
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [REG_W-1:0] SP = REG_W'(SP_REG);

    vop_state_t          state_q;
    logic [NUM_REGS-1:0] mask_q;
    logic [1:0]          pred_q;
    logic [8:0]          regs_q;
    logic                push_q;
    logic                last_q;

    logic [8:0]          cap_regs;
    logic [NUM_REGS-1:0] cap_mask;
    logic [3:0]          cap_cnt;
    logic                slot_end;
    logic                pick_msb;
    logic [IDX_W-1:0]    pk_idx;
    logic [NUM_REGS-1:0] pk_oh;
    logic                pk_last;

    function automatic op_t stack_op(input logic push, input logic [IDX_W-1:0] idx,
                                     input logic [1:0] pred);
        op_t op;
        if (push) begin
            op   = OP_ST;
            op.b = REG_W'(idx);
        end else begin
            op   = OP_LD;
            op.a = REG_W'(idx);
        end
        op.p     = pred;
        op.p_inv = 1'b0;
        return op;
    endfunction

    // PUSH: ADDR <- SP - n.  POP: SP <- SP + n with ADDR <- SP.
    function automatic op_t addr_op(input logic push, input logic [1:0] pred);
        op_t op;
        op   = OP_ADDR;
        op.b = SP;
        op.p = pred;
        if (push) begin
            op.alu_rhs_inv = 1'b1;
            op.alu_cin     = 1'b1;
            op.wr_addr     = 1'b1;
        end else begin
            op.a        = SP;
            op.a_vld    = 1'b1;
            op.addr_lhs = 1'b1;
        end
        return op;
    endfunction

    // Register image as it stands at the last decode cycle, including the
    // low nibble arriving on that very cycle.
    always_comb begin
        cap_regs = regs_q;
        if (i_vop_ctr == 2'd3 && i_vop_enc_vld) begin
            cap_regs[3:0] = i_vop_enc;
        end
    end

    assign cap_mask = cap_regs[NUM_REGS-1:0];
    assign cap_cnt  = popcnt4(9'(cap_mask));
    assign slot_end = (i_vop_ctr == 2'd3) && !i_vop_hold;

`ifdef IDLI_VOP_POP_REVERSE_EN
    assign pick_msb = !push_q;
`else
    assign pick_msb = 1'b0;
`endif

    // The mask register holds the bits not yet emitted; the op on the output
    // already owns the bit the picker removed.
    idli_vop_pick_m #(
        .N     (NUM_REGS),
        .IDX_W (IDX_W)
    ) u_pick (
        .mask      (mask_q),
        .msb_first (pick_msb),
        .idx       (pk_idx),
        .onehot    (pk_oh),
        .last      (pk_last)
    );

    assign o_vop_busy = (state_q != IDLE);

    // Decode capture plus slot-boundary state machine with registered op outputs.
    always_ff @(posedge i_vop_gck or negedge i_vop_rst_n) begin
        if (!i_vop_rst_n) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            pred_q       <= '0;
            regs_q       <= '0;
            push_q       <= 1'b0;
            last_q       <= 1'b0;
            o_vop_op     <= '0;
            o_vop_op_vld <= 1'b0;
            o_vop_imm    <= '0;
        end else begin
            if (state_q == IDLE && i_vop_type_vld && i_vop_enc_vld) begin
                case (i_vop_ctr)
                    2'd0:    pred_q      <= i_vop_enc[2:1];
                    2'd1:    regs_q[8]   <= i_vop_enc[0];
                    2'd2:    regs_q[7:4] <= i_vop_enc;
                    default: regs_q[3:0] <= i_vop_enc;
                endcase
            end
            if (slot_end) begin
                case (state_q)
                    IDLE: begin
                        if (i_vop_type_vld) begin
                            push_q <= (i_vop_type == VOP_ST);
                            if (i_vop_stack) begin
                                mask_q <= cap_mask;
                                if (cap_mask == '0) begin
                                    o_vop_op     <= '0;
                                    o_vop_op_vld <= 1'b0;
                                    o_vop_imm    <= '0;
                                end else begin
                                    state_q      <= ADDR;
                                    o_vop_op     <= addr_op(i_vop_type == VOP_ST, pred_q);
                                    o_vop_op_vld <= 1'b1;
                                    o_vop_imm    <= cap_cnt;
                                end
                            end else if (i_vop_type == VOP_LD) begin
                                state_q      <= LD;
                                o_vop_op     <= '{p: pred_q, p_inv: 1'b0,
                                                  a: {1'b0, cap_regs[8:6]}, a_vld: 1'b1,
                                                  b: '0, alu_lhs: LHS_SQI,
                                                  alu_rhs: RHS_ZERO, alu_rhs_inv: 1'b0,
                                                  alu_cin: 1'b0, wr_sqi: 1'b0,
                                                  wr_addr: 1'b0, addr_lhs: 1'b0};
                                o_vop_op_vld <= 1'b1;
                                o_vop_imm    <= '0;
                            end else begin
                                state_q      <= ST;
                                o_vop_op     <= '{p: pred_q, p_inv: 1'b0,
                                                  a: '0, a_vld: 1'b0,
                                                  b: {1'b0, cap_regs[5:3]},
                                                  alu_lhs: LHS_REG,
                                                  alu_rhs: RHS_ZERO, alu_rhs_inv: 1'b0,
                                                  alu_cin: 1'b0, wr_sqi: 1'b1,
                                                  wr_addr: 1'b0, addr_lhs: 1'b0};
                                o_vop_op_vld <= 1'b1;
                                o_vop_imm    <= '0;
                            end
                        end
                    end
                    ADDR: begin
                        state_q      <= push_q ? STK_ST : STK_LD;
                        mask_q       <= mask_q & ~pk_oh;
                        last_q       <= pk_last;
                        o_vop_op     <= stack_op(push_q, pk_idx, pred_q);
                        o_vop_op_vld <= 1'b1;
                        o_vop_imm    <= '0;
                    end
                    STK_LD, STK_ST: begin
                        if (last_q) begin
                            state_q      <= IDLE;
                            o_vop_op     <= '0;
                            o_vop_op_vld <= 1'b0;
                        end else begin
                            mask_q       <= mask_q & ~pk_oh;
                            last_q       <= pk_last;
                            o_vop_op     <= stack_op(push_q, pk_idx, pred_q);
                            o_vop_op_vld <= 1'b1;
                        end
                        o_vop_imm <= '0;
                    end
                    default: begin
                        state_q      <= IDLE;
                        o_vop_op     <= '0;
                        o_vop_op_vld <= 1'b0;
                        o_vop_imm    <= '0;
                    end
                endcase
            end
        end
    end

    // Decode must not present a new virtual op while the sequencer owns the pipe;
    // the RTL ignores it, this flags the protocol error in simulation.
    a_no_issue_while_busy: assert property (@(posedge i_vop_gck) disable iff (!i_vop_rst_n)
        !(i_vop_type_vld && o_vop_busy))
        else $error("idli_vop_seq_m: virtual op issued while busy");

endmodule

// File: tb/tb_idli_vop_seq_m.sv
// Directed scoreboard bench for idli_vop_seq_m (NUM_REGS=8, SP_REG=7).
module tb_idli_vop_seq_m;
    import idli_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] enc;
    logic       enc_vld;
    vop_type_t  vtype;
    logic       type_vld;
    logic       stack;
    logic [1:0] ctr;
    logic       hold;
    op_t        op;
    logic       op_vld;
    logic [3:0] imm;
    logic       busy;

    always #5 clk = ~clk;

    idli_vop_seq_m #(.NUM_REGS(8), .SP_REG(7)) dut (
        .i_vop_gck      (clk),
        .i_vop_rst_n    (rst_n),
        .i_vop_enc      (enc),
        .i_vop_enc_vld  (enc_vld),
        .i_vop_type     (vtype),
        .i_vop_type_vld (type_vld),
        .i_vop_stack    (stack),
        .i_vop_ctr      (ctr),
        .i_vop_hold     (hold),
        .o_vop_op       (op),
        .o_vop_op_vld   (op_vld),
        .o_vop_imm      (imm),
        .o_vop_busy     (busy)
    );

    typedef struct packed {
        op_t        op;
        logic [3:0] imm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic op_t e_ld(input int a, input int p);
        op_t o = '0;
        o.p = 2'(p); o.a = 4'(a); o.a_vld = 1'b1;
        o.alu_lhs = LHS_SQI; o.alu_rhs = RHS_ZERO;
        return o;
    endfunction

    function automatic op_t e_st(input int b, input int p);
        op_t o = '0;
        o.p = 2'(p); o.b = 4'(b);
        o.alu_lhs = LHS_REG; o.alu_rhs = RHS_ZERO; o.wr_sqi = 1'b1;
        return o;
    endfunction

    function automatic op_t e_push_addr(input int p);
        op_t o = '0;
        o.p = 2'(p); o.b = 4'd7;
        o.alu_lhs = LHS_REG; o.alu_rhs = RHS_IMM;
        o.alu_rhs_inv = 1'b1; o.alu_cin = 1'b1; o.wr_addr = 1'b1;
        return o;
    endfunction

    function automatic op_t e_pop_addr(input int p);
        op_t o = '0;
        o.p = 2'(p); o.a = 4'd7; o.a_vld = 1'b1; o.b = 4'd7;
        o.alu_lhs = LHS_REG; o.alu_rhs = RHS_IMM; o.addr_lhs = 1'b1;
        return o;
    endfunction

    task automatic expect_op(input op_t o, input int i);
        exp_t e;
        e.op  = o;
        e.imm = 4'(i);
        sb.push_back(e);
    endtask

    task automatic cyc(input logic [1:0] c, input logic [3:0] e, input logic tv,
                       input vop_type_t t, input logic st, input logic h);
        ctr = c; enc = e; enc_vld = tv; type_vld = tv; vtype = t; stack = st; hold = h;
        @(posedge clk);
        #1;
    endtask

    // Compare the op the DUT presents for the coming slot against the scoreboard.
    task automatic observe();
        exp_t e;
        if (op_vld) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("op", 32'(op), 32'(e.op));
                check("imm", 32'(imm), 32'(e.imm));
            end
        end
    endtask

    task automatic slot(input logic tv, input vop_type_t t, input logic st,
                        input logic [8:0] regs, input logic [1:0] p, input logic h);
        cyc(2'd0, {1'b0, p, 1'b0}, tv, t, st, h);
        cyc(2'd1, {3'b000, regs[8]}, tv, t, st, h);
        cyc(2'd2, regs[7:4], tv, t, st, h);
        cyc(2'd3, regs[3:0], tv, t, st, h);
        observe();
    endtask

    task automatic idle_slot(input logic h);
        slot(1'b0, VOP_LD, 1'b0, 9'd0, 2'd0, h);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((busy || op_vld) && k < 16) begin
            idle_slot(1'b0);
            k++;
        end
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, observed timeout expected summary");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; enc = '0; enc_vld = 0; vtype = VOP_LD; type_vld = 0;
        stack = 0; ctr = '0; hold = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", 32'(op_vld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_imm", 32'(imm), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Non-stack LD: A=5, pred=2.
        expect_op(e_ld(5, 2), 0);
        slot(1'b1, VOP_LD, 1'b0, 9'b101_011_000, 2'd2, 1'b0);
        check("ld_busy", 32'(busy), 32'd1);
        idle_slot(1'b0);
        check("ld_vld_one_slot", 32'(op_vld), 32'd0);
        drain("ld");

        // Non-stack ST: B=6, pred=1.
        expect_op(e_st(6, 1), 0);
        slot(1'b1, VOP_ST, 1'b0, 9'b000_110_000, 2'd1, 1'b0);
        drain("st");

        // PUSH mask 1000_0101.
        expect_op(e_push_addr(0), 3);
        expect_op(e_st(0, 0), 0);
        expect_op(e_st(2, 0), 0);
        expect_op(e_st(7, 0), 0);
        slot(1'b1, VOP_ST, 1'b1, 9'b0_1000_0101, 2'd0, 1'b0);
        drain("push");

        // POP mask 0000_0110, pred=3.
        expect_op(e_pop_addr(3), 2);
`ifdef IDLI_VOP_POP_REVERSE_EN
        expect_op(e_ld(2, 3), 0);
        expect_op(e_ld(1, 3), 0);
`else
        expect_op(e_ld(1, 3), 0);
        expect_op(e_ld(2, 3), 0);
`endif
        slot(1'b1, VOP_LD, 1'b1, 9'b0_0000_0110, 2'd3, 1'b0);
        drain("pop");

        // Hold for two slots while the second ST is presented.
        expect_op(e_push_addr(1), 3);
        expect_op(e_st(0, 1), 0);
        expect_op(e_st(2, 1), 0);
        expect_op(e_st(2, 1), 0);
        expect_op(e_st(2, 1), 0);
        expect_op(e_st(7, 1), 0);
        slot(1'b1, VOP_ST, 1'b1, 9'b0_1000_0101, 2'd1, 1'b0);
        idle_slot(1'b0);
        idle_slot(1'b0);
        idle_slot(1'b1);
        idle_slot(1'b1);
        idle_slot(1'b0);
        drain("hold");

        // Empty-mask PUSH: nothing issued.
        slot(1'b1, VOP_ST, 1'b1, 9'd0, 2'd0, 1'b0);
        check("empty_vld", 32'(op_vld), 32'd0);
        check("empty_busy", 32'(busy), 32'd0);
        drain("empty");

        // Async reset at ctr=2 while in STK_ST.
        expect_op(e_push_addr(0), 3);
        expect_op(e_st(0, 0), 0);
        slot(1'b1, VOP_ST, 1'b1, 9'b0_1000_0101, 2'd0, 1'b0);
        idle_slot(1'b0);
        check("pre_rst_busy", 32'(busy), 32'd1);
        cyc(2'd0, 4'd0, 1'b0, VOP_LD, 1'b0, 1'b0);
        cyc(2'd1, 4'd0, 1'b0, VOP_LD, 1'b0, 1'b0);
        ctr = 2'd2;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 32'(op_vld), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_imm", 32'(imm), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_op(e_ld(3, 3), 0);
        slot(1'b1, VOP_LD, 1'b0, 9'b011_000_000, 2'd3, 1'b0);
        check("post_rst_vld", 32'(op_vld), 32'd1);
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
